// File: rtl/cam_sdram_pkg.sv
// cam_sdram_pkg: constants, state encoding and plane-offset helper shared by the
//   camera store controller and the SDRAM RGB reader.
//   No ports. Plane layout in SDRAM: R at base+i, G at base+i+PIXEL_COUNT,
//   B at base+i+2*PIXEL_COUNT.
package cam_sdram_pkg;
   localparam int SDRAM_AW        = 19;
   localparam int SDRAM_DW        = 16;
   localparam int PIXEL_COUNT_DEF = 4096;
   localparam int R_OFS           = 0;
   localparam int G_OFS           = PIXEL_COUNT_DEF;
   localparam int B_OFS           = 2 * PIXEL_COUNT_DEF;
   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_CHECK  = 4'd1,
      ST_REQ_R  = 4'd2,
      ST_WAIT_R = 4'd3,
      ST_REQ_G  = 4'd4,
      ST_WAIT_G = 4'd5,
      ST_REQ_B  = 4'd6,
      ST_WAIT_B = 4'd7,
      ST_PUSH   = 4'd8,
      ST_FINISH = 4'd9
   } state_e;
   // Offset of plane k (0=R, 1=G, 2=B) for a given frame size, wrapped to the bus width.
   function automatic logic [SDRAM_AW-1:0] plane_offset(input logic [1:0] plane, input int pixel_count);
      return SDRAM_AW'(int'(plane) * pixel_count);
   endfunction
endpackage

// File: rtl/rgb565_pack.sv
// rgb565_pack: combinational RGB565 packer; owns the plane unpack bit selects.
//   i_r, i_g, i_b : 16-bit SDRAM plane words (plane value in the low byte)
//   o_rgb         : {R[5:1], G[5:0], B[5:1]} of the low bytes
module rgb565_pack
   import cam_sdram_pkg::*;
(
   input  logic [SDRAM_DW-1:0] i_r,
   input  logic [SDRAM_DW-1:0] i_g,
   input  logic [SDRAM_DW-1:0] i_b,
   output logic [SDRAM_DW-1:0] o_rgb
);
   logic unused_bits;
   assign o_rgb       = {i_r[5:1], i_g[5:0], i_b[5:1]};
   // Upper bits and the R/B LSB carry no pixel information.
   assign unused_bits = ^{i_r[15:6], i_r[0], i_g[15:6], i_b[15:6], i_b[0]};
endmodule

// File: rtl/sdram_rgb_reader.sv
// sdram_rgb_reader: reads R/G/B planes of a frame back from SDRAM and pushes
//   RGB565 pixels into a downstream write FIFO.
//   i_clk, i_reset (async, active-low)
//   i_start            : starts a frame read (sampled only in IDLE)
//   i_sdramReady       : read data valid on i_dataSdram
//   i_fifoFull         : downstream FIFO full (sampled only in CHECK)
//   o_rdSdram          : one-cycle read request at o_addressToSdram
//   o_wrFifo           : one-cycle FIFO write of o_dataFifo
//   o_busy, o_finish   : frame in progress / one-cycle end-of-frame pulse
//   o_fmtErr           : only with SDRAM_RGB_READER_CHECK_EN; sticky format error
module sdram_rgb_reader
   import cam_sdram_pkg::*;
#(
   parameter int                  PIXEL_COUNT = PIXEL_COUNT_DEF,
   parameter logic [SDRAM_AW-1:0] BASE_ADDR   = '0
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_start,
   input  logic                i_sdramReady,
   input  logic [SDRAM_DW-1:0] i_dataSdram,
   input  logic                i_fifoFull,
   output logic                o_rdSdram,
   output logic [SDRAM_AW-1:0] o_addressToSdram,
   output logic                o_wrFifo,
   output logic [SDRAM_DW-1:0] o_dataFifo,
   output logic                o_busy,
   output logic                o_finish
`ifdef SDRAM_RGB_READER_CHECK_EN
   ,output logic               o_fmtErr
`endif
);
   localparam int IDX_W = ($clog2(PIXEL_COUNT) > 13) ? $clog2(PIXEL_COUNT) : 13;
   state_e              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SDRAM_DW-1:0] r_q, r_d, g_q, g_d, b_q, b_d, data_q, data_d, packed_w;
   logic [SDRAM_AW-1:0] addr_q, addr_d;
   logic                rd_q, rd_d, wr_q, wr_d, busy_q, busy_d, finish_q, finish_d;
   logic                is_req;
   logic [1:0]          plane;
   rgb565_pack u_pack (
      .i_r   (r_d),
      .i_g   (g_d),
      .i_b   (b_d),
      .o_rgb (packed_w)
   );
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      r_d     = r_q;
      g_d     = g_q;
      b_d     = b_q;
      unique case (state_q)
         ST_IDLE:   if (i_start) begin state_d = ST_CHECK; idx_d = '0; end
         ST_CHECK:  if (!i_fifoFull) state_d = ST_REQ_R;
         ST_REQ_R:  state_d = ST_WAIT_R;
         ST_WAIT_R: if (i_sdramReady) begin r_d = i_dataSdram; state_d = ST_REQ_G; end
         ST_REQ_G:  state_d = ST_WAIT_G;
         ST_WAIT_G: if (i_sdramReady) begin g_d = i_dataSdram; state_d = ST_REQ_B; end
         ST_REQ_B:  state_d = ST_WAIT_B;
         ST_WAIT_B: if (i_sdramReady) begin b_d = i_dataSdram; state_d = ST_PUSH; end
         ST_PUSH: begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (idx_q == IDX_W'(PIXEL_COUNT - 1)) ? ST_FINISH : ST_CHECK;
         end
         ST_FINISH: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
      // Outputs are decoded from the next state so the registered copies line up with state_q.
      is_req   = state_d inside {ST_REQ_R, ST_REQ_G, ST_REQ_B};
      plane    = (state_d == ST_REQ_G) ? 2'd1 : (state_d == ST_REQ_B) ? 2'd2 : 2'd0;
      rd_d     = is_req;
      addr_d   = is_req ? BASE_ADDR + SDRAM_AW'(idx_d) + plane_offset(plane, PIXEL_COUNT) : addr_q;
      wr_d     = state_d == ST_PUSH;
      data_d   = wr_d ? packed_w : data_q;
      busy_d   = state_d != ST_IDLE;
      finish_d = state_d == ST_FINISH;
   end
`ifdef SDRAM_RGB_READER_CHECK_EN
   logic fmt_err_q, fmt_err_d, capture, bad_word;
   always_comb begin
      capture   = i_sdramReady && (state_q inside {ST_WAIT_R, ST_WAIT_G, ST_WAIT_B});
      // G uses all six low bits; R and B drop bit 0, so a set bit 0 there is a format error.
      bad_word  = (|i_dataSdram[15:6]) || (i_dataSdram[0] && state_q != ST_WAIT_G);
      fmt_err_d = (state_q == ST_IDLE && i_start) ? 1'b0 : (fmt_err_q || (capture && bad_word));
   end
   always_ff @(posedge i_clk or negedge i_reset)
      if (!i_reset) fmt_err_q <= 1'b0;
      else          fmt_err_q <= fmt_err_d;
   assign o_fmtErr = fmt_err_q;
`endif
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         r_q      <= '0;
         g_q      <= '0;
         b_q      <= '0;
         data_q   <= '0;
         addr_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         r_q      <= r_d;
         g_q      <= g_d;
         b_q      <= b_d;
         data_q   <= data_d;
         addr_q   <= addr_d;
         rd_q     <= rd_d;
         wr_q     <= wr_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
      end
   end
   assign o_rdSdram        = rd_q;
   assign o_addressToSdram = addr_q;
   assign o_wrFifo         = wr_q;
   assign o_dataFifo       = data_q;
   assign o_busy           = busy_q;
   assign o_finish         = finish_q;
endmodule
